// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller downstream of the trap stage.
// Owns mstatus (MIE/MPIE), mtvec, mscratch, mepc and mcause, sequences the
// pipeline flush and PC redirect for traps and MRET, and reports the
// interrupt-enable and vector configuration back to the trap stage.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   MEM_WAIT            global stall, freezes every register
//   TRAP_EN/PC/CODE/JMP_TO  trap request, faulting PC, cause, handler address
//   MRET_EN             MRET retiring this cycle
//   CSR_WREN/WADDR/WDATA    CSR write port
//   CSR_RADDR/RDATA     CSR read port, data registered one cycle later
//   FLUSH, JMP_EN, JMP_PC   flush strobe and PC redirect
//   INT_ALLOW           interrupts may be taken
//   TRAP_VEC_MODE/BASE  mtvec mode and aligned base
//
// state  | meaning
// IDLE   | accepting trap, MRET and CSR writes
// FLUSH  | FLUSH asserted for one cycle
// JUMP   | JMP_EN asserted, held through MEM_WAIT
// SETTLE | one dead cycle before returning to IDLE
module trap_ctrl #(
  parameter logic [31:0] RESET_VEC_BASE = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_WAIT,
  input  logic        TRAP_EN,
  input  logic [31:0] TRAP_PC,
  input  logic [31:0] TRAP_CODE,
  input  logic [31:0] TRAP_JMP_TO,
  input  logic        MRET_EN,
  input  logic        CSR_WREN,
  input  logic [11:0] CSR_WADDR,
  input  logic [31:0] CSR_WDATA,
  input  logic [11:0] CSR_RADDR,
  output logic [31:0] CSR_RDATA,
  output logic        FLUSH,
  output logic        JMP_EN,
  output logic [31:0] JMP_PC,
  output logic        INT_ALLOW,
  output logic [1:0]  TRAP_VEC_MODE,
  output logic [31:0] TRAP_VEC_BASE
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_JUMP   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;

  logic [1:0]  state;
  logic        mie;
  logic        mpie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] target;
  logic [31:0] rdata_reg;
  logic [31:0] rd_mux;

  // The low PC bits are always discarded when saving mepc.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^TRAP_PC[1:0];

  always_comb begin
    rd_mux = 32'h0;
    case (CSR_RADDR)
      A_MSTATUS:  rd_mux = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
      A_MTVEC:    rd_mux = mtvec;
      A_MSCRATCH: rd_mux = mscratch;
      A_MEPC:     rd_mux = mepc;
      A_MCAUSE:   rd_mux = mcause;
      default:    rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      mie       <= 1'b0;
      mpie      <= 1'b0;
      mtvec     <= {RESET_VEC_BASE[31:2], 2'b00};
      mscratch  <= 32'h0;
      mepc      <= 32'h0;
      mcause    <= 32'h0;
      target    <= 32'h0;
      rdata_reg <= 32'h0;
    end else if (!MEM_WAIT) begin
      rdata_reg <= rd_mux;
      case (state)
        ST_IDLE: begin
          if (TRAP_EN) begin
            mepc   <= {TRAP_PC[31:2], 2'b00};
            mcause <= TRAP_CODE;
            mpie   <= mie;
            mie    <= 1'b0;
            target <= TRAP_JMP_TO;
            state  <= ST_FLUSH;
          end else if (MRET_EN) begin
            mie    <= mpie;
            mpie   <= 1'b1;
            target <= mepc;
            state  <= ST_FLUSH;
          end else if (CSR_WREN) begin
            case (CSR_WADDR)
              A_MSTATUS: begin
                mie  <= CSR_WDATA[3];
                mpie <= CSR_WDATA[7];
              end
              A_MTVEC:    mtvec    <= CSR_WDATA;
              A_MSCRATCH: mscratch <= CSR_WDATA;
              A_MEPC:     mepc     <= {CSR_WDATA[31:2], 2'b00};
              A_MCAUSE:   mcause   <= CSR_WDATA;
              default: ;
            endcase
          end
        end
        ST_FLUSH:  state <= ST_JUMP;
        ST_JUMP:   state <= ST_SETTLE;
        ST_SETTLE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign CSR_RDATA     = rdata_reg;
  assign FLUSH         = (state == ST_FLUSH);
  assign JMP_EN        = (state == ST_JUMP);
  assign JMP_PC        = JMP_EN ? target : 32'h0;
  assign INT_ALLOW     = mie && (state == ST_IDLE);
  assign TRAP_VEC_MODE = mtvec[1:0];
  assign TRAP_VEC_BASE = {mtvec[31:2], 2'b00};

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_WAIT;
  logic        TRAP_EN;
  logic [31:0] TRAP_PC;
  logic [31:0] TRAP_CODE;
  logic [31:0] TRAP_JMP_TO;
  logic        MRET_EN;
  logic        CSR_WREN;
  logic [11:0] CSR_WADDR;
  logic [31:0] CSR_WDATA;
  logic [11:0] CSR_RADDR;
  logic [31:0] CSR_RDATA;
  logic        FLUSH;
  logic        JMP_EN;
  logic [31:0] JMP_PC;
  logic        INT_ALLOW;
  logic [1:0]  TRAP_VEC_MODE;
  logic [31:0] TRAP_VEC_BASE;

  int pass_cnt = 0;
  int total = 0;

  trap_ctrl #(.RESET_VEC_BASE(32'h40)) dut (
    .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT),
    .TRAP_EN(TRAP_EN), .TRAP_PC(TRAP_PC), .TRAP_CODE(TRAP_CODE),
    .TRAP_JMP_TO(TRAP_JMP_TO), .MRET_EN(MRET_EN),
    .CSR_WREN(CSR_WREN), .CSR_WADDR(CSR_WADDR), .CSR_WDATA(CSR_WDATA),
    .CSR_RADDR(CSR_RADDR), .CSR_RDATA(CSR_RDATA),
    .FLUSH(FLUSH), .JMP_EN(JMP_EN), .JMP_PC(JMP_PC),
    .INT_ALLOW(INT_ALLOW), .TRAP_VEC_MODE(TRAP_VEC_MODE),
    .TRAP_VEC_BASE(TRAP_VEC_BASE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
    CSR_WREN = 1'b1; CSR_WADDR = addr; CSR_WDATA = data;
    step();
    CSR_WREN = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    CSR_RADDR = addr;
    step();
    chk(tag, CSR_RDATA, exp);
  endtask

  task automatic trap(input logic [31:0] pc, input logic [31:0] code, input logic [31:0] to);
    TRAP_EN = 1'b1; TRAP_PC = pc; TRAP_CODE = code; TRAP_JMP_TO = to;
    step();
    TRAP_EN = 1'b0;
  endtask

  initial begin
    RST = 1'b1; MEM_WAIT = 1'b0; TRAP_EN = 1'b0; TRAP_PC = '0; TRAP_CODE = '0;
    TRAP_JMP_TO = '0; MRET_EN = 1'b0; CSR_WREN = 1'b0; CSR_WADDR = '0;
    CSR_WDATA = '0; CSR_RADDR = '0;
    step(); step();
    RST = 1'b0;

    // reset state
    chk("rst_flush", {31'b0, FLUSH}, 32'h0);
    chk("rst_jmp_en", {31'b0, JMP_EN}, 32'h0);
    chk("rst_jmp_pc", JMP_PC, 32'h0);
    chk("rst_rdata", CSR_RDATA, 32'h0);
    chk("rst_int_allow", {31'b0, INT_ALLOW}, 32'h0);
    chk("rst_vec_base", TRAP_VEC_BASE, 32'h40);
    chk("rst_vec_mode", {30'b0, TRAP_VEC_MODE}, 32'h0);
    csr_rd("rst_mstatus", 12'h300, 32'h1800);

    // sync trap
    csr_wr(12'h305, 32'h100);
    chk("mtvec_base", TRAP_VEC_BASE, 32'h100);
    trap(32'h2004, 32'h2, 32'h100);
    chk("t1_flush", {31'b0, FLUSH}, 32'h1);
    chk("t1_jmp_en_f", {31'b0, JMP_EN}, 32'h0);
    CSR_RADDR = 12'h341;
    step();
    chk("t1_flush_one", {31'b0, FLUSH}, 32'h0);
    chk("t1_jmp_en", {31'b0, JMP_EN}, 32'h1);
    chk("t1_jmp_pc", JMP_PC, 32'h100);
    chk("t1_mepc", CSR_RDATA, 32'h2004);
    CSR_RADDR = 12'h342;
    step();
    chk("t1_settle_jmp", {31'b0, JMP_EN}, 32'h0);
    chk("t1_mcause", CSR_RDATA, 32'h2);
    CSR_RADDR = 12'h300;
    step();
    chk("t1_mstatus", CSR_RDATA, 32'h1800);

    // trap then MRET
    csr_wr(12'h300, 32'h8);
    chk("t2_int_allow", {31'b0, INT_ALLOW}, 32'h1);
    trap(32'h3000, 32'hB, 32'h200);
    chk("t2_int_blocked", {31'b0, INT_ALLOW}, 32'h0);
    step();
    chk("t2_jmp_pc", JMP_PC, 32'h200);
    step(); step();
    csr_rd("t2_mstatus_trap", 12'h300, 32'h1880);
    MRET_EN = 1'b1;
    step();
    MRET_EN = 1'b0;
    chk("t2_mret_flush", {31'b0, FLUSH}, 32'h1);
    step();
    chk("t2_mret_jmp_en", {31'b0, JMP_EN}, 32'h1);
    chk("t2_mret_jmp_pc", JMP_PC, 32'h3000);
    step(); step();
    csr_rd("t2_mstatus_mret", 12'h300, 32'h1888);
    chk("t2_int_allow2", {31'b0, INT_ALLOW}, 32'h1);

    // simultaneous trap, MRET and CSR write
    TRAP_EN = 1'b1; MRET_EN = 1'b1; CSR_WREN = 1'b1;
    CSR_WADDR = 12'h340; CSR_WDATA = 32'hDEAD;
    TRAP_PC = 32'h4000; TRAP_CODE = 32'h7; TRAP_JMP_TO = 32'h500;
    step();
    TRAP_EN = 1'b0; MRET_EN = 1'b0; CSR_WREN = 1'b0;
    chk("t3_flush", {31'b0, FLUSH}, 32'h1);
    step();
    chk("t3_jmp_pc", JMP_PC, 32'h500);
    step(); step();
    csr_rd("t3_mscratch", 12'h340, 32'h0);
    csr_rd("t3_mcause", 12'h342, 32'h7);

    // MEM_WAIT during JUMP
    trap(32'h5008, 32'h3, 32'h600);
    step();
    chk("t4_jmp_en0", {31'b0, JMP_EN}, 32'h1);
    MEM_WAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_jmp_en_hold", {31'b0, JMP_EN}, 32'h1);
      chk("t4_jmp_pc_hold", JMP_PC, 32'h600);
    end
    MEM_WAIT = 1'b0;
    step();
    chk("t4_settle", {31'b0, JMP_EN}, 32'h0);
    step();
    csr_rd("t4_mepc", 12'h341, 32'h5008);

    // back-to-back trap held high
    TRAP_EN = 1'b1; TRAP_PC = 32'h6000; TRAP_CODE = 32'h5; TRAP_JMP_TO = 32'h700;
    step();
    chk("t5_flush_a", {31'b0, FLUSH}, 32'h1);
    TRAP_PC = 32'h7000; TRAP_JMP_TO = 32'h800;
    step();
    chk("t5_jmp_a", JMP_PC, 32'h700);
    step();
    step();
    chk("t5_idle", {31'b0, FLUSH}, 32'h0);
    step();
    TRAP_EN = 1'b0;
    chk("t5_flush_b", {31'b0, FLUSH}, 32'h1);
    step();
    chk("t5_jmp_b", JMP_PC, 32'h800);
    step(); step();

    // reset mid-sequence
    csr_wr(12'h300, 32'h8);
    csr_wr(12'h340, 32'h55);
    trap(32'h8000, 32'h1, 32'h900);
    chk("t6_flush", {31'b0, FLUSH}, 32'h1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t6_flush_rst", {31'b0, FLUSH}, 32'h0);
    chk("t6_jmp_en_rst", {31'b0, JMP_EN}, 32'h0);
    chk("t6_jmp_pc_rst", JMP_PC, 32'h0);
    chk("t6_rdata_rst", CSR_RDATA, 32'h0);
    chk("t6_int_rst", {31'b0, INT_ALLOW}, 32'h0);
    chk("t6_vec_rst", TRAP_VEC_BASE, 32'h40);
    step();
    chk("t6_no_jmp", {31'b0, JMP_EN}, 32'h0);
    csr_rd("t6_mscratch", 12'h340, 32'h0);
    csr_rd("t6_mepc", 12'h341, 32'h0);

    // CSR masking
    csr_wr(12'h341, 32'hFFFF_FFFF);
    csr_wr(12'h305, 32'h8000_0101);
    chk("t7_vec_mode", {30'b0, TRAP_VEC_MODE}, 32'h1);
    chk("t7_vec_base", TRAP_VEC_BASE, 32'h8000_0100);
    csr_rd("t7_mepc", 12'h341, 32'hFFFF_FFFC);
    csr_rd("t7_mtvec", 12'h305, 32'h8000_0101);
    csr_rd("t7_unsup", 12'h7C0, 32'h0);
    csr_wr(12'h300, 32'hFFFF_FFFF);
    csr_rd("t7_mstatus", 12'h300, 32'h1888);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap controller that sits directly downstream of the `trap` stage. It consumes `TRAP_EN`, `TRAP_PC`, `TRAP_CODE` and `TRAP_JMP_TO`, and executes MRET requests from the pipeline. It owns the trap CSRs (mstatus, mtvec, mscratch, mepc, mcause), sequences the pipeline flush and the PC redirect, and feeds `INT_ALLOW`, `TRAP_VEC_MODE` and `TRAP_VEC_BASE` back to `trap`.

## Interface
Parameters:
- `RESET_VEC_BASE`, default 32'h0: reset value of mtvec (base field; mode bits reset to 0).

Ports (reset is synchronous and active-high, sampled on the rising edge of `CLK`):
- `CLK`  in  1  clock.
- `RST`  in  1  synchronous active-high reset.
- `MEM_WAIT`  in  1  global stall; freezes all state.
- `TRAP_EN`  in  1  trap request from `trap`.
- `TRAP_PC`  in  32  faulting or interrupted PC.
- `TRAP_CODE`  in  32  cause value.
- `TRAP_JMP_TO`  in  32  handler address.
- `MRET_EN`  in  1  MRET retiring this cycle.
- `CSR_WREN`  in  1  CSR write strobe.
- `CSR_WADDR`  in  12  CSR write address.
- `CSR_WDATA`  in  32  CSR write data.
- `CSR_RADDR`  in  12  CSR read address.
- `CSR_RDATA`  out  32  registered read data, one cycle after `CSR_RADDR`.
- `FLUSH`  out  1  pipeline flush, including `trap`.
- `JMP_EN`  out  1  PC redirect valid.
- `JMP_PC`  out  32  redirect target.
- `INT_ALLOW`  out  1  interrupts may be taken.
- `TRAP_VEC_MODE`  out  2  mtvec[1:0].
- `TRAP_VEC_BASE`  out  32  {mtvec[31:2], 2'b00}.

## Operation
FSM states: IDLE, FLUSH, JUMP, SETTLE.

- **IDLE, `TRAP_EN`=1, `MEM_WAIT`=0:**
  - mepc <= {TRAP_PC[31:2], 2'b00}.
  - mcause <= TRAP_CODE.
  - MPIE <= MIE; MIE <= 0.
  - Latch target <= TRAP_JMP_TO.
  - Go to FLUSH.
- **IDLE, `MRET_EN`=1, `TRAP_EN`=0, `MEM_WAIT`=0:**
  - MIE <= MPIE; MPIE <= 1.
  - Latch target <= mepc (value before any same-cycle write).
  - Go to FLUSH.
- **FLUSH:** `FLUSH`=1 for exactly one cycle, then go to JUMP.
- **JUMP:** `JMP_EN`=1, `JMP_PC`=target. Hold while `MEM_WAIT`. Leave to SETTLE on the first cycle with `MEM_WAIT`=0.
- **SETTLE:** one dead cycle, then IDLE.
- **Outside IDLE:** `TRAP_EN`, `MRET_EN` and `CSR_WREN` are ignored; those sources belong to flushed instructions.
- **Priority in IDLE:** `TRAP_EN` > `MRET_EN` > `CSR_WREN`. A CSR write coincident with a trap or MRET is dropped.
- **CSR write (IDLE, no trap or MRET, `MEM_WAIT`=0):**
  - 0x300 mstatus: only MIE (bit 3) and MPIE (bit 7) are writable.
  - 0x305 mtvec: full 32 bits stored.
  - 0x340 mscratch: full 32 bits stored.
  - 0x341 mepc: bits [1:0] forced to 0.
  - 0x342 mcause: full 32 bits stored.
  - Other addresses: ignored.
- **CSR read:**
  - mstatus reads {19'b0, 2'b11 (MPP), 3'b0, MPIE, 3'b0, MIE, 3'b0}.
  - Unsupported addresses read 0.
  - Reads are not blocked by FSM state.
- **`INT_ALLOW`** = MIE && state==IDLE (combinational from registers).
- **`MEM_WAIT`=1:** every register holds, including `CSR_RDATA`, the FSM state, and the `FLUSH` output level.

## Timing
- **Reset values:**
  - state=IDLE; `FLUSH`=0; `JMP_EN`=0; `JMP_PC`=0; `CSR_RDATA`=0.
  - MIE=0, MPIE=0, mepc=0, mcause=0, mscratch=0.
  - mtvec=RESET_VEC_BASE; `INT_ALLOW`=0.
- **Trap latency:** trap sampled at edge N.
  - Cycle N+1: `FLUSH`=1; new mepc, mcause and mstatus are visible on reads issued from N+1.
  - Cycle N+2: `JMP_EN`=1.
  - Cycle N+3: SETTLE.
  - Cycle N+4: IDLE, accepting new requests.
- MRET uses the same latency.
- `TRAP_VEC_*` reflect an mtvec write from the cycle after the write edge.
- **Reset mid-sequence:** `RST` in any state returns to IDLE next edge with all reset values. No `JMP_EN` is emitted.
- **Back-to-back traps:** a `TRAP_EN` held through FLUSH, JUMP and SETTLE is ignored. If still high in IDLE at N+4, it is taken as a new trap.

## Test plan
- **Reset, then sync trap:** write mtvec=0x100. Pulse `TRAP_EN` with PC=0x2004, CODE=2, JMP_TO=0x100. Required: `FLUSH` high 1 cycle; next cycle `JMP_EN`=1, `JMP_PC`=0x100; mepc reads 0x2004; mcause reads 2; MIE=0.
- **Trap then MRET:** set MIE=1 via mstatus write 0x8. Take trap (PC=0x3000), then pulse `MRET_EN`. Required: `JMP_PC`=0x3000; mstatus reads 0x1888 after MRET (MIE=1, MPIE=1, MPP=3).
- **Simultaneous events:** assert `TRAP_EN`, `MRET_EN` and `CSR_WREN` (mscratch<=0xDEAD) in one cycle. Required: trap path taken; mscratch unchanged at 0.
- **`MEM_WAIT` in JUMP:** hold `MEM_WAIT` 3 cycles during JUMP. Required: `JMP_EN` stays 1 with a stable `JMP_PC` for 4 cycles; then SETTLE, then IDLE.
- **Reset mid-sequence:** assert `RST` in FLUSH. Required: next cycle all outputs at reset values; no `JMP_EN` pulse.
- **CSR masking:** write mepc=0xFFFF_FFFF and mtvec=0x8000_0101. Required: mepc reads 0xFFFF_FFFC; `TRAP_VEC_MODE`=1; `TRAP_VEC_BASE`=0x8000_0100; read of 0x7C0 returns 0.
